dof_ex_operand_stage: RTL and testbench
=======================================

Name: dof_ex_operand_stage

Overview:
- Pipeline boundary between DOF and EX in the hw5 RISC CPU.
- Resolves source operands by forwarding from EX and WB results, and detects load-use hazards.
- Stalls IF/DOF and injects a bubble into EX when a hazard is detected.
- Registers the resolved operands and control into the DOF/EX pipeline register, and keeps saturating hazard statistics counters.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width (R0..R31)
- CTRL_W, 16, opaque EX/WB control bundle width (FS, MW, MD, etc.), passed through unchanged
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dof_valid  in  1  DOF holds a real instruction
- dof_dr  in  REG_AW  destination register
- dof_sa  in  REG_AW  source A address
- dof_sb  in  REG_AW  source B address
- dof_use_a  in  1  instruction reads SA
- dof_use_b  in  1  instruction reads SB (0 when MB selects constant)
- dof_bus_a  in  DATA_W  register file value for SA
- dof_bus_b  in  DATA_W  register file value, or constant when dof_use_b=0
- dof_reg_write  in  1  instruction writes DR
- dof_is_load  in  1  instruction is LD
- dof_ctrl  in  CTRL_W  control bundle
- ex_result  in  DATA_W  ALU result of instruction currently in EX
- wb_data  in  DATA_W  final write-back data (ALU or memory)
- wb_dr  in  REG_AW  WB destination
- wb_reg_write  in  1  WB writes register file this cycle
- flush  in  1  kill the instruction entering EX (branch taken)
- stall  out  1  hold PC and IF/DOF register
- ex_valid  out  1  registered: EX holds a real instruction
- ex_bus_a  out  DATA_W  registered resolved operand A
- ex_bus_b  out  DATA_W  registered resolved operand B
- ex_dr  out  REG_AW  registered destination
- ex_reg_write  out  1  registered write-enable (forced 0 on bubble)
- ex_is_load  out  1  registered load flag (forced 0 on bubble)
- ex_ctrl  out  CTRL_W  registered control (forced 0 on bubble)
- stall_count  out  CNT_W  saturating count of load-use stall cycles
- fwd_count  out  CNT_W  saturating count of cycles with at least one forwarded operand

Behaviour:
- Reset, synchronous on clk rising edge: all registered outputs and both counters go to 0. stall is combinational but gated low while rst=1. Reset mid-stall drops the bubble and the stall.
- Match X: dof_valid & dof_use_X & src≠0 & src==ex_dr & ex_valid & ex_reg_write.
- Match WB: same conditions against wb_dr and wb_reg_write.
- Operand select, per operand, in priority order:
  - EX match and ex_is_load=0: ex_result.
  - Else WB match: wb_data.
  - Else the dof_bus value.
- R0 is never forwarded.
- Forwarding applies only to bus_b when dof_use_b=1; when dof_use_b=0 the constant passes through.
- Load-use hazard: an EX match on either used operand while ex_is_load=1.
- On hazard:
  - stall=1.
  - Next edge loads a bubble: ex_valid, ex_reg_write, ex_is_load and ex_ctrl are 0; the bus and dr registers hold their values.
  - The following cycle the load is in WB and its data forwards via wb_data. Stall lasts exactly 1 cycle per load.
- flush=1:
  - Next edge loads a bubble.
  - stall is forced 0. Flush wins over a hazard, because the stalled instruction is dead.
- No hazard and no flush: latency 1. The next edge captures resolved operands and all dof_* fields; ex_valid=dof_valid.
- dof_valid=0 loads a bubble and never stalls.
- stall_count increments on each edge where stall=1. fwd_count increments on each edge that captures a non-bubble with any forwarded operand. Both saturate at all-ones and do not wrap.
- WB forwarding is required even though the register file writes in the same cycle: the read/write ordering of the register file is not relied upon.

Test Plan:
- R1=0x12345678; ADD R2,R1,R0 then ADD R3,R2,R0: second capture has ex_bus_a=0x12345678 via the EX path, stall never 1, fwd_count=1.
- ADD R4,R1,R0; NOP; ADD R5,R4,R0: R5 capture takes ex_bus_a=0x12345678 from wb_data, dof_bus_a is stale 0.
- LD R6,[R1] (mem=0xAABBCCDD); ADD R7,R6,R0:
  - stall=1 for exactly one cycle and a bubble appears with ex_valid=0, ex_reg_write=0.
  - The next capture has ex_bus_a=0xAABBCCDD, stall_count=1.
- ADD R8; ADD R9,R8; ADD R10,R8,R9: R10 capture has bus_a from WB and bus_b from EX, both 0x12345678. EX priority holds when EX and WB both target the same register.
- Writer targets R0 with ex_result=0xDEADBEEF, then reader uses R0: the operand equals dof_bus_a (0) and there is no stall on an R0 load.
- Flush asserted during a load-use stall: stall drops the same cycle and a bubble is captured. Then rst for one cycle mid-stream: all outputs and counters read 0. Counters preloaded near all-ones saturate.

Source files
------------

// File: rtl/dof_ex_operand_stage_if.sv
// rtl/dof_ex_operand_stage_if.sv - DOF/EX boundary signal bundle
// slave is the stage itself; master is whatever drives DOF, EX feedback and WB.
interface dof_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic              dof_valid;
  logic [REG_AW-1:0] dof_dr;
  logic [REG_AW-1:0] dof_sa;
  logic [REG_AW-1:0] dof_sb;
  logic              dof_use_a;
  logic              dof_use_b;
  logic [DATA_W-1:0] dof_bus_a;
  logic [DATA_W-1:0] dof_bus_b;
  logic              dof_reg_write;
  logic              dof_is_load;
  logic [CTRL_W-1:0] dof_ctrl;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] wb_dr;
  logic              wb_reg_write;
  logic              flush;

  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_bus_a;
  logic [DATA_W-1:0] ex_bus_b;
  logic [REG_AW-1:0] ex_dr;
  logic              ex_reg_write;
  logic              ex_is_load;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  fwd_count;

  modport slave (
    input  dof_valid, dof_dr, dof_sa, dof_sb, dof_use_a, dof_use_b,
           dof_bus_a, dof_bus_b, dof_reg_write, dof_is_load, dof_ctrl,
           ex_result, wb_data, wb_dr, wb_reg_write, flush,
    output stall, ex_valid, ex_bus_a, ex_bus_b, ex_dr, ex_reg_write,
           ex_is_load, ex_ctrl, stall_count, fwd_count
  );

  modport master (
    output dof_valid, dof_dr, dof_sa, dof_sb, dof_use_a, dof_use_b,
           dof_bus_a, dof_bus_b, dof_reg_write, dof_is_load, dof_ctrl,
           ex_result, wb_data, wb_dr, wb_reg_write, flush,
    input  stall, ex_valid, ex_bus_a, ex_bus_b, ex_dr, ex_reg_write,
           ex_is_load, ex_ctrl, stall_count, fwd_count
  );
endinterface

// File: rtl/dof_ex_operand_stage.sv
// rtl/dof_ex_operand_stage.sv - DOF/EX pipeline register with forwarding and load-use stall
// Operands are resolved EX-first then WB; a load in EX feeding DOF costs one bubble.
module dof_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  dof_ex_operand_stage_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_bus_a;
  logic [DATA_W-1:0] r_ex_bus_b;
  logic [REG_AW-1:0] r_ex_dr;
  logic              r_ex_reg_write;
  logic              r_ex_is_load;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_fwd_count;

  logic              w_ex_writes;
  logic              w_req_a;
  logic              w_req_b;
  logic              w_ex_hit_a;
  logic              w_ex_hit_b;
  logic              w_wb_hit_a;
  logic              w_wb_hit_b;
  logic              w_fwd_ex_a;
  logic              w_fwd_ex_b;
  logic              w_fwd_wb_a;
  logic              w_fwd_wb_b;
  logic              w_any_fwd;
  logic              w_hazard;
  logic              w_stall;
  logic              w_bubble;
  logic [DATA_W-1:0] w_bus_a;
  logic [DATA_W-1:0] w_bus_b;

  // R0 is hardwired zero, so a write to it must never be forwarded.
  assign w_ex_writes = r_ex_valid & r_ex_reg_write;
  assign w_req_a     = bus.dof_valid & bus.dof_use_a & (bus.dof_sa != '0);
  assign w_req_b     = bus.dof_valid & bus.dof_use_b & (bus.dof_sb != '0);

  assign w_ex_hit_a  = w_req_a & w_ex_writes & (bus.dof_sa == r_ex_dr);
  assign w_ex_hit_b  = w_req_b & w_ex_writes & (bus.dof_sb == r_ex_dr);
  assign w_wb_hit_a  = w_req_a & bus.wb_reg_write & (bus.dof_sa == bus.wb_dr);
  assign w_wb_hit_b  = w_req_b & bus.wb_reg_write & (bus.dof_sb == bus.wb_dr);

  assign w_fwd_ex_a  = w_ex_hit_a & ~r_ex_is_load;
  assign w_fwd_ex_b  = w_ex_hit_b & ~r_ex_is_load;
  assign w_fwd_wb_a  = ~w_fwd_ex_a & w_wb_hit_a;
  assign w_fwd_wb_b  = ~w_fwd_ex_b & w_wb_hit_b;
  assign w_any_fwd   = w_fwd_ex_a | w_fwd_wb_a | w_fwd_ex_b | w_fwd_wb_b;

  assign w_bus_a = w_fwd_ex_a ? bus.ex_result :
                   w_fwd_wb_a ? bus.wb_data   : bus.dof_bus_a;
  assign w_bus_b = w_fwd_ex_b ? bus.ex_result :
                   w_fwd_wb_b ? bus.wb_data   : bus.dof_bus_b;

  // A flushed instruction is dead, so it neither stalls nor enters EX.
  assign w_hazard = (w_ex_hit_a | w_ex_hit_b) & r_ex_is_load;
  assign w_stall  = w_hazard & ~bus.flush & ~i_rst;
  assign w_bubble = ~bus.dof_valid | bus.flush | w_hazard;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_bus_a     <= '0;
      r_ex_bus_b     <= '0;
      r_ex_dr        <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_ex_ctrl      <= '0;
    end else if (w_bubble) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_ex_ctrl      <= '0;
    end else begin
      r_ex_valid     <= 1'b1;
      r_ex_bus_a     <= w_bus_a;
      r_ex_bus_b     <= w_bus_b;
      r_ex_dr        <= bus.dof_dr;
      r_ex_reg_write <= bus.dof_reg_write;
      r_ex_is_load   <= bus.dof_is_load;
      r_ex_ctrl      <= bus.dof_ctrl;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_count <= '0;
      r_fwd_count   <= '0;
    end else begin
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
      if (!w_bubble && w_any_fwd && (r_fwd_count != '1)) begin
        r_fwd_count <= r_fwd_count + CNT_ONE;
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_bus_a     = r_ex_bus_a;
  assign bus.ex_bus_b     = r_ex_bus_b;
  assign bus.ex_dr        = r_ex_dr;
  assign bus.ex_reg_write = r_ex_reg_write;
  assign bus.ex_is_load   = r_ex_is_load;
  assign bus.ex_ctrl      = r_ex_ctrl;
  assign bus.stall_count  = r_stall_count;
  assign bus.fwd_count    = r_fwd_count;

endmodule

// File: tb/tb_dof_ex_operand_stage.sv
// tb/tb_dof_ex_operand_stage.sv - bench for dof_ex_operand_stage
// A second instance with 2-bit counters shares the stimulus to reach saturation quickly.
module tb_dof_ex_operand_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dof_ex_operand_stage_if                bus ();
  dof_ex_operand_stage_if #(.CNT_W(2))   bus_s ();

  dof_ex_operand_stage u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  dof_ex_operand_stage #(.CNT_W(2)) u_dut_s (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_s)
  );

  assign bus_s.dof_valid     = bus.dof_valid;
  assign bus_s.dof_dr        = bus.dof_dr;
  assign bus_s.dof_sa        = bus.dof_sa;
  assign bus_s.dof_sb        = bus.dof_sb;
  assign bus_s.dof_use_a     = bus.dof_use_a;
  assign bus_s.dof_use_b     = bus.dof_use_b;
  assign bus_s.dof_bus_a     = bus.dof_bus_a;
  assign bus_s.dof_bus_b     = bus.dof_bus_b;
  assign bus_s.dof_reg_write = bus.dof_reg_write;
  assign bus_s.dof_is_load   = bus.dof_is_load;
  assign bus_s.dof_ctrl      = bus.dof_ctrl;
  assign bus_s.ex_result     = bus.ex_result;
  assign bus_s.wb_data       = bus.wb_data;
  assign bus_s.wb_dr         = bus.wb_dr;
  assign bus_s.wb_reg_write  = bus.wb_reg_write;
  assign bus_s.flush         = bus.flush;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what EX should hold, plus unbounded event tallies.
  logic        m_valid, m_rw, m_ld;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_dr;
  logic [15:0] m_ctrl;
  int          m_stalls, m_fwds;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] resolve(input logic use_x, input logic [4:0] src,
                                          input logic [31:0] rf, output bit fwd,
                                          output bit load_use);
    fwd = 0;
    load_use = 0;
    if (!(bus.dof_valid && use_x && src != 5'd0)) return rf;
    if (m_valid && m_rw && src == m_dr) begin
      if (m_ld) begin
        load_use = 1;
        return rf;
      end
      fwd = 1;
      return bus.ex_result;
    end
    if (bus.wb_reg_write && src == bus.wb_dr) begin
      fwd = 1;
      return bus.wb_data;
    end
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_ld = 0; m_a = 0; m_b = 0; m_dr = 0; m_ctrl = 0;
    m_stalls = 0; m_fwds = 0;
  endtask

  task automatic cycle();
    bit          fa, fb, la, lb, hazard, exp_stall, capture;
    logic [31:0] na, nb;
    #1;
    na = resolve(bus.dof_use_a, bus.dof_sa, bus.dof_bus_a, fa, la);
    nb = resolve(bus.dof_use_b, bus.dof_sb, bus.dof_bus_b, fb, lb);
    hazard    = la | lb;
    exp_stall = hazard && !bus.flush && !rst;
    capture   = bus.dof_valid && !bus.flush && !hazard;
    check("stall", bus.stall, exp_stall);
    check("stall_s", bus_s.stall, exp_stall);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (exp_stall) m_stalls++;
      if (capture) begin
        m_valid = 1; m_a = na; m_b = nb; m_dr = bus.dof_dr;
        m_rw = bus.dof_reg_write; m_ld = bus.dof_is_load; m_ctrl = bus.dof_ctrl;
        if (fa || fb) m_fwds++;
      end else begin
        m_valid = 0; m_rw = 0; m_ld = 0; m_ctrl = 0;
      end
    end
    #1;
    check("ex_valid", bus.ex_valid, m_valid);
    check("ex_bus_a", bus.ex_bus_a, m_a);
    check("ex_bus_b", bus.ex_bus_b, m_b);
    check("ex_dr", bus.ex_dr, m_dr);
    check("ex_reg_write", bus.ex_reg_write, m_rw);
    check("ex_is_load", bus.ex_is_load, m_ld);
    check("ex_ctrl", bus.ex_ctrl, m_ctrl);
    check("stall_count", bus.stall_count, sat(m_stalls, 65535));
    check("fwd_count", bus.fwd_count, sat(m_fwds, 65535));
    check("stall_count_sat", bus_s.stall_count, sat(m_stalls, 3));
    check("fwd_count_sat", bus_s.fwd_count, sat(m_fwds, 3));
  endtask

  task automatic set_instr(input logic v, input logic [4:0] dr, input logic [4:0] sa,
                           input logic [4:0] sb, input logic ua, input logic ub,
                           input logic [31:0] ba, input logic [31:0] bb,
                           input logic rw, input logic ld);
    bus.dof_valid = v; bus.dof_dr = dr; bus.dof_sa = sa; bus.dof_sb = sb;
    bus.dof_use_a = ua; bus.dof_use_b = ub; bus.dof_bus_a = ba; bus.dof_bus_b = bb;
    bus.dof_reg_write = rw; bus.dof_is_load = ld; bus.dof_ctrl = 16'h00A5;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.ex_result = 0; bus.wb_data = 0; bus.wb_dr = 0; bus.wb_reg_write = 0; bus.flush = 0;
    @(posedge clk); #1;
    cycle();
    cycle();
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_stall_count", bus.stall_count, 0);
    rst = 1'b0;

    // ADD R2,R1,R0 then ADD R3,R2,R0: EX path forward
    set_instr(1, 5'd2, 5'd1, 5'd0, 1, 1, 32'h12345678, 0, 1, 0);
    cycle();
    bus.ex_result = 32'h12345678;
    set_instr(1, 5'd3, 5'd2, 5'd0, 1, 1, 32'h0, 0, 1, 0);
    cycle();
    check("ex_fwd_bus_a", bus.ex_bus_a, 32'h12345678);
    check("ex_fwd_count", bus.fwd_count, 1);

    // LD R6,[R1] then ADD R7,R6,R0: one stall, then WB forward
    set_instr(1, 5'd6, 5'd1, 5'd0, 1, 0, 32'h12345678, 0, 1, 1);
    cycle();
    set_instr(1, 5'd7, 5'd6, 5'd0, 1, 1, 32'h0, 0, 1, 0);
    cycle();
    check("lu_bubble", bus.ex_valid, 0);
    bus.wb_dr = 5'd6; bus.wb_reg_write = 1; bus.wb_data = 32'hAABBCCDD;
    cycle();
    check("lu_bus_a", bus.ex_bus_a, 32'hAABBCCDD);
    check("lu_stall_count", bus.stall_count, 1);
    bus.wb_reg_write = 0;

    // Load-use with flush in the stall cycle
    set_instr(1, 5'd6, 5'd1, 5'd0, 1, 0, 0, 0, 1, 1);
    cycle();
    set_instr(1, 5'd7, 5'd6, 5'd0, 1, 1, 0, 0, 1, 0);
    bus.flush = 1;
    cycle();
    bus.flush = 0;

    // R0 writer followed by R0 reader, and an R0 load
    bus.ex_result = 32'hDEADBEEF;
    set_instr(1, 5'd0, 5'd1, 5'd0, 1, 1, 0, 0, 1, 1);
    cycle();
    set_instr(1, 5'd9, 5'd0, 5'd0, 1, 1, 0, 0, 1, 0);
    cycle();
    check("r0_bus_a", bus.ex_bus_a, 0);

    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                $urandom, $urandom, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0);
      bus.dof_ctrl     = 16'($urandom);
      bus.ex_result    = $urandom;
      bus.wb_data      = $urandom;
      bus.wb_dr        = 5'($urandom_range(0, 3));
      bus.wb_reg_write = $urandom_range(0, 1);
      bus.flush        = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
